// File: rtl/l2norm_stream_scheduler.sv
// Packet-level round-robin scheduler sharing one L2-norm engine between NUM_SRC streams.
// Each granted packet's source ID is queued so that engine results come back tagged.
module l2norm_stream_scheduler #(
  parameter int NUM_SRC   = 4,
  parameter int SRC_W     = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [64*NUM_SRC-1:0]   io_src_tdata,
  input  logic [NUM_SRC-1:0]      io_src_tvalid,
  input  logic [NUM_SRC-1:0]      io_src_tlast,
  output logic [NUM_SRC-1:0]      io_src_tready,
  output logic [63:0]             io_eng_in_tdata,
  output logic                    io_eng_in_tvalid,
  output logic                    io_eng_in_tlast,
  input  logic                    io_eng_in_tready,
  input  logic [31:0]             io_eng_out_tdata,
  input  logic                    io_eng_out_tvalid,
  output logic                    io_eng_out_tready,
  output logic [31:0]             io_res_tdata,
  output logic [SRC_W-1:0]        io_res_tid,
  output logic                    io_res_tvalid,
  input  logic                    io_res_tready,
  output logic                    io_busy,
  output logic                    io_err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CW    = SRC_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

  state_t             state_reg;
  logic [SRC_W-1:0]   grant_reg;
  logic [SRC_W-1:0]   rr_ptr_reg;
  logic [SRC_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               err_orphan_reg;

  logic [63:0]        src_data [NUM_SRC];
  logic               any_valid;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   rr_ptr_next;
  logic               tag_empty;
  logic               tag_full;
  logic               tag_pop;
  logic               grant_fire;
  logic               stream_active;

  assign stream_active = (state_reg == ST_STREAM);

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      localparam logic [SRC_W-1:0] SRC_IDX = SRC_W'(gi);
      assign src_data[gi]      = io_src_tdata[64*gi +: 64];
      assign io_src_tready[gi] = stream_active && (grant_reg == SRC_IDX) && io_eng_in_tready;
    end
  endgenerate

  // Round-robin search: scanning offsets high-to-low lets the closest valid source after ptr win.
  always_comb begin
    logic [CW-1:0] cand;
    any_valid = |io_src_tvalid;
    winner    = rr_ptr_reg;
    cand      = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_reg} + CW'(i);
      if (cand >= CW'(NUM_SRC)) begin
        cand = cand - CW'(NUM_SRC);
      end
      if (io_src_tvalid[cand[SRC_W-1:0]]) begin
        winner = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_next = winner + SRC_W'(1);
    if (winner == SRC_W'(NUM_SRC - 1)) begin
      rr_ptr_next = '0;
    end
  end

  assign io_eng_in_tdata  = src_data[grant_reg];
  assign io_eng_in_tvalid = stream_active && io_src_tvalid[grant_reg];
  assign io_eng_in_tlast  = io_src_tlast[grant_reg];

  assign tag_empty  = (count_reg == '0);
  assign tag_full   = (count_reg == (PTR_W+1)'(TAG_DEPTH));
  assign tag_pop    = io_eng_out_tvalid && io_res_tready && !tag_empty;
  // A full FIFO may still accept a new grant when a result drains in the same cycle.
  assign grant_fire = !stream_active && any_valid && (!tag_full || tag_pop);

  assign io_res_tdata      = io_eng_out_tdata;
  assign io_res_tid        = tag_mem[rd_ptr_reg];
  assign io_res_tvalid     = io_eng_out_tvalid && !tag_empty;
  assign io_eng_out_tready = (io_res_tready && !tag_empty) || tag_empty;
  assign io_busy           = stream_active || !tag_empty;
  assign io_err_orphan     = err_orphan_reg;

  always_ff @(posedge clock) begin
    if (grant_fire) begin
      tag_mem[wr_ptr_reg] <= winner;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_fire) begin
            grant_reg  <= winner;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (io_eng_in_tvalid && io_eng_in_tready && io_eng_in_tlast) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (grant_fire) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (tag_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({grant_fire, tag_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase

      // Results with no outstanding tag are accepted and dropped; the flag stays until reset.
      if (io_eng_out_tvalid && tag_empty) begin
        err_orphan_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2norm_stream_scheduler.sv
// Bench for l2norm_stream_scheduler: directed scenarios plus random traffic against a
// queue-based reference model of the scheduling and tagging rules.
module tb_l2norm_stream_scheduler;

  localparam int N     = 4;
  localparam int SW    = 2;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [64*N-1:0] src_tdata = '0;
  logic [N-1:0]    src_tvalid = '0;
  logic [N-1:0]    src_tlast = '0;
  logic [N-1:0]    src_tready;
  logic [63:0]     eng_in_tdata;
  logic            eng_in_tvalid;
  logic            eng_in_tlast;
  logic            eng_in_tready = 1'b0;
  logic [31:0]     eng_out_tdata = '0;
  logic            eng_out_tvalid = 1'b0;
  logic            eng_out_tready;
  logic [31:0]     res_tdata;
  logic [SW-1:0]   res_tid;
  logic            res_tvalid;
  logic            res_tready = 1'b0;
  logic            busy;
  logic            err_orphan;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_stream;
  int m_grant;
  int m_ptr;
  int m_q[$];
  bit m_orphan;

  // Expected outputs for the current cycle
  logic [N-1:0] e_src_tready;
  logic         e_in_valid;
  logic [63:0]  e_in_data;
  logic         e_in_last;
  logic         e_res_valid;
  int           e_tid;
  logic         e_out_ready;
  logic         e_busy;

  always #5 clock = ~clock;

  l2norm_stream_scheduler #(.NUM_SRC(N), .SRC_W(SW), .TAG_DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_src_tdata      (src_tdata),
    .io_src_tvalid     (src_tvalid),
    .io_src_tlast      (src_tlast),
    .io_src_tready     (src_tready),
    .io_eng_in_tdata   (eng_in_tdata),
    .io_eng_in_tvalid  (eng_in_tvalid),
    .io_eng_in_tlast   (eng_in_tlast),
    .io_eng_in_tready  (eng_in_tready),
    .io_eng_out_tdata  (eng_out_tdata),
    .io_eng_out_tvalid (eng_out_tvalid),
    .io_eng_out_tready (eng_out_tready),
    .io_res_tdata      (res_tdata),
    .io_res_tid        (res_tid),
    .io_res_tvalid     (res_tvalid),
    .io_res_tready     (res_tready),
    .io_busy           (busy),
    .io_err_orphan     (err_orphan)
  );

  task automatic predict();
    e_src_tready = '0;
    if (m_stream && eng_in_tready) e_src_tready[m_grant] = 1'b1;
    e_in_valid  = m_stream && src_tvalid[m_grant];
    e_in_data   = src_tdata[64*m_grant +: 64];
    e_in_last   = src_tlast[m_grant];
    e_res_valid = eng_out_tvalid && (m_q.size() > 0);
    e_tid       = (m_q.size() > 0) ? m_q[0] : 0;
    e_out_ready = (m_q.size() == 0) || res_tready;
    e_busy      = m_stream || (m_q.size() > 0);
  endtask

  // Advance the model by one clock using the inputs currently applied, then step the clock.
  task automatic tick();
    int w;
    bit pop;
    if (reset) begin
      m_stream = 0; m_grant = 0; m_ptr = 0; m_orphan = 0;
      m_q.delete();
    end else begin
      pop = (m_q.size() > 0) && eng_out_tvalid && res_tready;
      if (eng_out_tvalid && m_q.size() == 0) m_orphan = 1;
      if (!m_stream) begin
        w = -1;
        for (int i = 0; i < N; i++) begin
          int c = (m_ptr + i) % N;
          if (w < 0 && src_tvalid[c]) w = c;
        end
        if (pop) void'(m_q.pop_front());
        if (w >= 0 && (m_q.size() < DEPTH)) begin
          m_q.push_back(w);
          m_stream = 1; m_grant = w; m_ptr = (w + 1) % N;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (src_tvalid[m_grant] && eng_in_tready && src_tlast[m_grant]) m_stream = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_tvalid = '0; src_tlast = '0;
    eng_out_tvalid = 1'b0; eng_in_tready = 1'b0; res_tready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    eng_out_tvalid = 1'b1;
    #3;
    checks++; if (src_tready !== 4'b0000) begin errors++; $display("FAIL reset_src_tready: got %b expected 0000", src_tready); end
    checks++; if (eng_in_tvalid !== 1'b0) begin errors++; $display("FAIL reset_eng_in_tvalid: got %b expected 0", eng_in_tvalid); end
    checks++; if (res_tvalid !== 1'b0) begin errors++; $display("FAIL reset_res_tvalid: got %b expected 0", res_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (eng_out_tready !== 1'b1) begin errors++; $display("FAIL reset_eng_out_tready: got %b expected 1", eng_out_tready); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b expected 0", err_orphan); end
    eng_out_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_single_packet();
    do_reset();
    eng_in_tready = 1'b1; res_tready = 1'b1;
    src_tvalid[0] = 1'b1; src_tdata[63:0] = 64'd1; src_tlast[0] = 1'b0;
    #3;
    checks++; if (src_tready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready: got %b expected 0000", src_tready); end
    tick();
    for (int b = 1; b <= 3; b++) begin
      src_tdata[63:0] = 64'(b); src_tlast[0] = (b == 3);
      #3;
      checks++; if (src_tready !== 4'b0001) begin errors++; $display("FAIL single_beat_ready: beat %0d got %b expected 0001", b, src_tready); end
      checks++; if (eng_in_tdata !== 64'(b)) begin errors++; $display("FAIL single_beat_data: got %0h expected %0h", eng_in_tdata, b); end
      checks++; if (eng_in_tlast !== (b == 3)) begin errors++; $display("FAIL single_beat_last: beat %0d got %b", b, eng_in_tlast); end
      tick();
    end
    src_tvalid = '0;
    eng_out_tvalid = 1'b1; eng_out_tdata = 32'h0E;
    #3;
    checks++; if (res_tvalid !== 1'b1) begin errors++; $display("FAIL single_res_valid: got %b expected 1", res_tvalid); end
    checks++; if (res_tdata !== 32'h0E) begin errors++; $display("FAIL single_res_data: got %0h expected e", res_tdata); end
    checks++; if (res_tid !== 2'd0) begin errors++; $display("FAIL single_res_tid: got %0d expected 0", res_tid); end
    $display("single: result data=%0h tid=%0d", res_tdata, res_tid);
    tick();
    eng_out_tvalid = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_round_robin();
    int bcnt[N];
    do_reset();
    eng_in_tready = 1'b1; res_tready = 1'b1;
    for (int s = 0; s < N; s++) begin
      bcnt[s] = 0;
      src_tdata[64*s +: 64] = 64'hA0 + 64'(s);
    end
    src_tvalid = '1;
    for (int k = 0; k < 5; k++) begin
      int g = k % N;
      if (k > 0) begin eng_out_tvalid = 1'b1; eng_out_tdata = 32'(k - 1); end
      #3;
      checks++; if (src_tready !== 4'b0000) begin errors++; $display("FAIL rr_bubble: pkt %0d got %b expected 0000", k, src_tready); end
      if (k > 0) begin
        checks++; if (res_tid !== 2'((k - 1) % N) || res_tvalid !== 1'b1) begin errors++; $display("FAIL rr_tid: pkt %0d got tid %0d valid %b expected tid %0d valid 1", k - 1, res_tid, res_tvalid, (k - 1) % N); end
        $display("rr: result %0d tid=%0d", k - 1, res_tid);
      end
      tick();
      eng_out_tvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < N; s++) src_tlast[s] = (bcnt[s] == 1);
        #3;
        checks++; if (src_tready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant: pkt %0d beat %0d got %b expected %b", k, b, src_tready, 4'(1 << g)); end
        checks++; if (eng_in_tdata !== 64'hA0 + 64'(g)) begin errors++; $display("FAIL rr_data: got %0h expected %0h", eng_in_tdata, 64'hA0 + 64'(g)); end
        tick();
        bcnt[g] ^= 1;
      end
    end
    src_tvalid = '0;
    eng_out_tvalid = 1'b1; eng_out_tdata = 32'd4;
    #3;
    checks++; if (res_tid !== 2'd0) begin errors++; $display("FAIL rr_last_tid: got %0d expected 0", res_tid); end
    tick();
    eng_out_tvalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    int drain_tid[4] = '{1, 2, 3, 0};
    do_reset();
    eng_in_tready = 1'b1; res_tready = 1'b1;
    for (int s = 0; s < N; s++) src_tdata[64*s +: 64] = 64'hA0 + 64'(s);
    src_tvalid = '1; src_tlast = '1;
    for (int p = 0; p < DEPTH; p++) begin
      #3; tick();
      #3;
      checks++; if (src_tready !== 4'(1 << p)) begin errors++; $display("FAIL full_grant: pkt %0d got %b expected %b", p, src_tready, 4'(1 << p)); end
      tick();
    end
    for (int t = 0; t < 3; t++) begin
      #3;
      checks++; if (src_tready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL full_hold: cycle %0d ready %b busy %b expected 0000/1", t, src_tready, busy); end
      tick();
    end
    eng_out_tvalid = 1'b1; eng_out_tdata = 32'h100;
    #3;
    checks++; if (res_tid !== 2'd0 || eng_out_tready !== 1'b1) begin errors++; $display("FAIL full_release: tid %0d ready %b expected 0/1", res_tid, eng_out_tready); end
    tick();
    eng_out_tvalid = 1'b0;
    #3;
    checks++; if (src_tready !== 4'b0001) begin errors++; $display("FAIL full_fifth_grant: got %b expected 0001", src_tready); end
    tick();
    src_tvalid = '0;
    for (int t = 0; t < 4; t++) begin
      eng_out_tvalid = 1'b1;
      #3;
      checks++; if (res_tid !== 2'(drain_tid[t])) begin errors++; $display("FAIL full_drain_tid: got %0d expected %0d", res_tid, drain_tid[t]); end
      $display("full: drained tid=%0d", res_tid);
      tick();
    end
    eng_out_tvalid = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drained_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    eng_in_tready = 1'b1; res_tready = 1'b0;
    src_tvalid[2] = 1'b1; src_tlast = '1;
    #3; tick();
    #3;
    checks++; if (src_tready !== 4'b0100) begin errors++; $display("FAIL bp_grant2: got %b expected 0100", src_tready); end
    tick();
    src_tvalid = 4'b0010;
    #3; tick();
    #3;
    checks++; if (src_tready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b expected 0010", src_tready); end
    tick();
    src_tvalid = '0;
    eng_out_tvalid = 1'b1; eng_out_tdata = 32'h200;
    for (int t = 0; t < 3; t++) begin
      #3;
      checks++; if (eng_out_tready !== 1'b0 || res_tvalid !== 1'b1 || res_tid !== 2'd2) begin errors++; $display("FAIL bp_hold: ready %b valid %b tid %0d expected 0/1/2", eng_out_tready, res_tvalid, res_tid); end
      tick();
    end
    res_tready = 1'b1;
    #3;
    checks++; if (eng_out_tready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", eng_out_tready); end
    tick();
    res_tready = 1'b0; eng_out_tdata = 32'h201;
    #3;
    checks++; if (res_tid !== 2'd1 || res_tvalid !== 1'b1) begin errors++; $display("FAIL bp_one_pop: tid %0d valid %b expected 1/1", res_tid, res_tvalid); end
    src_tvalid = 4'b1000; res_tready = 1'b1;
    #1;
    tick();
    res_tready = 1'b0; eng_out_tdata = 32'h202;
    #3;
    checks++; if (src_tready !== 4'b1000) begin errors++; $display("FAIL bp_push_pop_grant: got %b expected 1000", src_tready); end
    checks++; if (res_tid !== 2'd3) begin errors++; $display("FAIL bp_push_pop_tid: got %0d expected 3", res_tid); end
    tick();
    src_tvalid = '0; res_tready = 1'b1;
    #3; tick();
    eng_out_tvalid = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_occupancy: busy %b expected 0", busy); end
    tick();
  endtask

  task automatic test_orphan();
    do_reset();
    eng_out_tvalid = 1'b1; eng_out_tdata = 32'hDEAD;
    #3;
    checks++; if (eng_out_tready !== 1'b1 || res_tvalid !== 1'b0) begin errors++; $display("FAIL orphan_accept: ready %b valid %b expected 1/0", eng_out_tready, res_tvalid); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_before: got %b expected 0", err_orphan); end
    tick();
    eng_out_tvalid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #3;
      checks++; if (err_orphan !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL orphan_sticky: cycle %0d flag %b busy %b expected 1/0", t, err_orphan, busy); end
      tick();
    end
  endtask

  task automatic test_reset_mid_packet();
    eng_in_tready = 1'b1; res_tready = 1'b1;
    src_tvalid = 4'b0010; src_tlast = '0;
    #3; tick();
    #3;
    checks++; if (src_tready !== 4'b0010) begin errors++; $display("FAIL rstmid_beat1: got %b expected 0010", src_tready); end
    tick();
    reset = 1'b1;
    #3; tick();
    reset = 1'b0;
    src_tvalid = '1;
    #3;
    checks++; if (src_tready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: ready %b busy %b expected 0000/0", src_tready, busy); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rstmid_orphan_clear: got %b expected 0", err_orphan); end
    tick();
    #3;
    checks++; if (src_tready !== 4'b0001) begin errors++; $display("FAIL rstmid_src0_wins: got %b expected 0001", src_tready); end
    src_tvalid = '0;
    tick();
  endtask

  task automatic test_random_traffic();
    int rem[N];
    int pend;
    bit hs_src[N];
    bit in_last_hs, out_hs;
    do_reset();
    pend = 0;
    for (int s = 0; s < N; s++) rem[s] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      predict();
      #3;
      checks++; if (src_tready !== e_src_tready) begin errors++; $display("FAIL rand_src_tready: cyc %0d got %b expected %b", cyc, src_tready, e_src_tready); end
      checks++; if (eng_in_tvalid !== e_in_valid) begin errors++; $display("FAIL rand_in_valid: cyc %0d got %b expected %b", cyc, eng_in_tvalid, e_in_valid); end
      if (e_in_valid) begin
        checks++; if (eng_in_tdata !== e_in_data || eng_in_tlast !== e_in_last) begin errors++; $display("FAIL rand_in_beat: cyc %0d got %0h/%b expected %0h/%b", cyc, eng_in_tdata, eng_in_tlast, e_in_data, e_in_last); end
      end
      checks++; if (res_tvalid !== e_res_valid) begin errors++; $display("FAIL rand_res_valid: cyc %0d got %b expected %b", cyc, res_tvalid, e_res_valid); end
      if (e_res_valid) begin
        checks++; if (res_tid !== 2'(e_tid) || res_tdata !== eng_out_tdata) begin errors++; $display("FAIL rand_res: cyc %0d got tid %0d data %0h expected tid %0d data %0h", cyc, res_tid, res_tdata, e_tid, eng_out_tdata); end
      end
      checks++; if (eng_out_tready !== e_out_ready || busy !== e_busy || err_orphan !== 1'b0) begin errors++; $display("FAIL rand_status: cyc %0d got ready %b busy %b orphan %b expected %b %b 0", cyc, eng_out_tready, busy, err_orphan, e_out_ready, e_busy); end
      for (int s = 0; s < N; s++) hs_src[s] = e_src_tready[s] && src_tvalid[s];
      in_last_hs = e_in_valid && eng_in_tready && e_in_last;
      out_hs     = eng_out_tvalid && e_out_ready;
      if (e_res_valid && res_tready) $display("rand: cyc %0d result tid=%0d data=%08h", cyc, e_tid, eng_out_tdata);
      tick();
      for (int s = 0; s < N; s++) begin
        if (hs_src[s]) begin
          rem[s]--;
          src_tvalid[s] = 1'b0;
        end
        if (!src_tvalid[s]) begin
          if (rem[s] == 0 && $urandom_range(3) == 0) rem[s] = 1 + $urandom_range(3);
          if (rem[s] > 0 && $urandom_range(1) == 1) begin
            src_tvalid[s] = 1'b1;
            src_tdata[64*s +: 64] = {$urandom, $urandom};
            src_tlast[s] = (rem[s] == 1);
          end
        end
      end
      if (in_last_hs) pend++;
      if (out_hs) eng_out_tvalid = 1'b0;
      if (!eng_out_tvalid && pend > 0 && $urandom_range(2) == 0) begin
        eng_out_tvalid = 1'b1;
        eng_out_tdata = $urandom;
        pend--;
      end
      eng_in_tready = ($urandom_range(3) != 0);
      res_tready = ($urandom_range(2) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_fifo_full();
    test_backpressure();
    test_orphan();
    test_reset_mid_packet();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
